// File: rtl/run_control_if.sv
// Button inputs and run/clear outputs shared between the run controller and its user.
interface run_control_if;
    logic       input_BTN_SS;
    logic       input_BTN_CLR;
    logic       output_ENA;
    logic       output_CLR;
    logic [1:0] output_STATE;

    modport master (
        output input_BTN_SS,
        output input_BTN_CLR,
        input  output_ENA,
        input  output_CLR,
        input  output_STATE
    );

    modport slave (
        input  input_BTN_SS,
        input  input_BTN_CLR,
        output output_ENA,
        output output_CLR,
        output output_STATE
    );
endinterface

// File: rtl/run_control.sv
// Start/stop/clear run controller: synchronised, debounced push buttons driving a three-state FSM.
//   state    | meaning
//   ST_IDLE  | stopped and cleared; SS starts, CLR re-pulses clear
//   ST_RUN   | downstream counter enabled; SS pauses, CLR ignored
//   ST_PAUSE | stopped, count held; SS resumes, CLR returns to idle
module run_control #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic         input_CLK,
    input  logic         input_RSTn,
    run_control_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

    logic [1:0] btn_raw;
    logic [1:0] press_ev;
    logic       ss_ev;
    logic       clr_ev;

    assign btn_raw = {bus.input_BTN_CLR, bus.input_BTN_SS};

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic             sync_1;
        logic             sync_2;
        logic             stable;
        logic             stable_q;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge input_CLK) begin
            if (!input_RSTn) begin
                sync_1   <= 1'b0;
                sync_2   <= 1'b0;
                stable   <= 1'b0;
                stable_q <= 1'b0;
                cnt      <= '0;
            end else begin
                sync_1   <= btn_raw[i];
                sync_2   <= sync_1;
                stable_q <= stable;
                // Any return to the stable level discards the partial count.
                if (sync_2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_TC) begin
                    stable <= sync_2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign press_ev[i] = stable & ~stable_q;
    end

    assign ss_ev  = press_ev[0];
    assign clr_ev = press_ev[1];

    state_t state;
    logic   ena_r;
    logic   clr_r;

    always_ff @(posedge input_CLK) begin
        if (!input_RSTn) begin
            state <= ST_IDLE;
            ena_r <= 1'b0;
            clr_r <= 1'b0;
        end else begin
            clr_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    clr_r <= clr_ev;
                    if (ss_ev) begin
                        state <= ST_RUN;
                        ena_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ss_ev) begin
                        state <= ST_PAUSE;
                        ena_r <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    // Clear takes priority over resume when both arrive together.
                    if (clr_ev) begin
                        state <= ST_IDLE;
                        clr_r <= 1'b1;
                    end else if (ss_ev) begin
                        state <= ST_RUN;
                        ena_r <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ena_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.output_ENA   = ena_r;
    assign bus.output_CLR   = clr_r;
    assign bus.output_STATE = state;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with a short debounce window (DB_CYCLES=4).
module tb_run_control;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    run_control_if bus ();

    run_control #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .input_CLK  (clk),
        .input_RSTn (rst_n),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic ena, input logic clr);
        chk({tag, ".state"}, {6'd0, bus.output_STATE}, {6'd0, st});
        chk({tag, ".ena"},   {7'd0, bus.output_ENA},   {7'd0, ena});
        chk({tag, ".clr"},   {7'd0, bus.output_CLR},   {7'd0, clr});
    endtask

    task automatic do_reset();
        bus.input_BTN_SS  = 1'b0;
        bus.input_BTN_CLR = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic ss, input logic clr);
        bus.input_BTN_SS  = ss;
        bus.input_BTN_CLR = clr;
        tick(8);
        bus.input_BTN_SS  = 1'b0;
        bus.input_BTN_CLR = 1'b0;
        tick(10);
    endtask

    initial begin
        int clr_seen;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.input_BTN_SS  = 1'b0;
        bus.input_BTN_CLR = 1'b0;

        // Reset values, then a clean held SS press.
        tick(2);
        chk_out("reset", 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus.input_BTN_SS = 1'b1;
        tick(6);
        chk_out("ss_edge6", 2'b00, 1'b0, 1'b0);
        tick(1);
        chk_out("ss_edge7", 2'b01, 1'b1, 1'b0);
        tick(13);
        chk_out("ss_held", 2'b01, 1'b1, 1'b0);
        bus.input_BTN_SS = 1'b0;
        tick(12);
        chk_out("ss_release", 2'b01, 1'b1, 1'b0);

        // Bouncing SS is rejected, then a clean hold is accepted once.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            bus.input_BTN_SS = 1'b1;
            tick(3);
            bus.input_BTN_SS = 1'b0;
            tick(1);
        end
        tick(8);
        chk_out("bounce", 2'b00, 1'b0, 1'b0);
        bus.input_BTN_SS = 1'b1;
        tick(10);
        chk_out("bounce_hold", 2'b01, 1'b1, 1'b0);
        bus.input_BTN_SS = 1'b0;
        tick(10);

        // SS, SS, CLR sequence with a single-cycle clear pulse.
        do_reset();
        press(1'b1, 1'b0);
        chk_out("seq_run", 2'b01, 1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk_out("seq_pause", 2'b10, 1'b0, 1'b0);
        bus.input_BTN_CLR = 1'b1;
        tick(6);
        chk_out("seq_clr_e6", 2'b10, 1'b0, 1'b0);
        tick(1);
        chk_out("seq_clr_e7", 2'b00, 1'b0, 1'b1);
        tick(1);
        chk_out("seq_clr_e8", 2'b00, 1'b0, 1'b0);
        bus.input_BTN_CLR = 1'b0;
        tick(10);

        // CLR is ignored while running.
        press(1'b1, 1'b0);
        chk_out("run_pre", 2'b01, 1'b1, 1'b0);
        clr_seen = 0;
        bus.input_BTN_CLR = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (k == 8) bus.input_BTN_CLR = 1'b0;
            if (bus.output_CLR) clr_seen++;
        end
        chk("run_clr_pulses", 8'(clr_seen), 8'd0);
        chk_out("run_clr", 2'b01, 1'b1, 1'b0);

        // Simultaneous SS+CLR in PAUSE: clear wins.
        press(1'b1, 1'b0);
        chk_out("pause_pre", 2'b10, 1'b0, 1'b0);
        bus.input_BTN_SS  = 1'b1;
        bus.input_BTN_CLR = 1'b1;
        tick(6);
        chk_out("both_pause_e6", 2'b10, 1'b0, 1'b0);
        tick(1);
        chk_out("both_pause_e7", 2'b00, 1'b0, 1'b1);
        tick(1);
        chk_out("both_pause_e8", 2'b00, 1'b0, 1'b0);
        bus.input_BTN_SS  = 1'b0;
        bus.input_BTN_CLR = 1'b0;
        tick(10);

        // Simultaneous SS+CLR in IDLE: run starts and clear pulses together.
        bus.input_BTN_SS  = 1'b1;
        bus.input_BTN_CLR = 1'b1;
        tick(7);
        chk_out("both_idle_e7", 2'b01, 1'b1, 1'b1);
        tick(1);
        chk_out("both_idle_e8", 2'b01, 1'b1, 1'b0);
        bus.input_BTN_SS  = 1'b0;
        bus.input_BTN_CLR = 1'b0;
        tick(10);

        // Simultaneous SS+CLR in RUN: pause, clear ignored.
        bus.input_BTN_SS  = 1'b1;
        bus.input_BTN_CLR = 1'b1;
        tick(7);
        chk_out("both_run_e7", 2'b10, 1'b0, 1'b0);
        bus.input_BTN_SS  = 1'b0;
        bus.input_BTN_CLR = 1'b0;
        tick(10);

        // Reset two cycles before acceptance aborts the press; held button re-accepted.
        do_reset();
        bus.input_BTN_SS = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk_out("midrst", 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(3);
        chk_out("midrst_e3", 2'b00, 1'b0, 1'b0);
        tick(3);
        chk_out("midrst_e6", 2'b00, 1'b0, 1'b0);
        tick(1);
        chk_out("midrst_e7", 2'b01, 1'b1, 1'b0);
        bus.input_BTN_SS = 1'b0;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
